reg_file: RTL
=============

Name: reg_file

Overview:
- Read side of the processor's storage.
- Provides 32 x 32-bit general registers, with one write port (Write-enabled, same semantics as the DFF cell) and two registered read ports feeding the A/B operand latches of the multicycle datapath.
- After reset, a clear-sweep state machine zeroes the array one entry per cycle before the file reports Ready. This keeps the array inferable as distributed/block RAM.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous active-low reset (0 = reset, sampled on Clk rising edge)
- Write  input  1  write enable; qualifies WAddr/WData on the rising edge
- WAddr  input  ADDR_W  write address
- WData  input  DATA_W  write data
- RAddrA  input  ADDR_W  read address, port A
- RAddrB  input  ADDR_W  read address, port B
- RDataA  output  DATA_W  registered read data, port A
- RDataB  output  DATA_W  registered read data, port B
- Ready  output  1  1 once the clear sweep is complete

Behaviour:
Clocking and reset:
- One clock (Clk); reset is synchronous and active-low (Reset = 0 sampled at a rising edge).
- On a reset edge:
  - state <= CLEAR, sweep counter <= 0
  - RDataA <= 0, RDataB <= 0, Ready <= 0
- Array contents are not reset directly; the sweep clears them.

FSM states:
- CLEAR:
  - Each cycle writes 0 to array[cnt], then cnt <= cnt + 1.
  - When cnt == 2**ADDR_W-1 and the write completes, go to RUN and set Ready <= 1 in the same edge.
  - Sweep takes exactly 2**ADDR_W cycles (32 by default) from reset deassertion.
- RUN:
  - Normal operation. Stays here until the next reset.

Behaviour during CLEAR:
- Write is ignored (no array update).
- RDataA and RDataB are registered as 0 every cycle.

Reads in RUN:
- Latency 1: RAddrX sampled at edge N appears on RDataX after edge N.
- RDataX holds until the next edge.

Writes in RUN:
- Write = 1 at an edge stores WData into array[WAddr].
- Write with WAddr = 0 is discarded. Reads of address 0 always return 0.

Bypass (write-first):
- If in RUN, Write = 1, WAddr == RAddrX and WAddr != 0 at the same edge, RDataX <= WData (the new value, not the stale one).
- Applies independently to A and B; both ports may bypass in the same cycle.

Other rules and boundary conditions:
- Both read ports reading the same address is legal; both return identical data.
- Sweep counter is ADDR_W+1 bits or terminal-compared; it must not wrap and re-clear.
- Reset asserted mid-sweep: counter restarts at 0, Ready stays 0, full 32-cycle sweep repeats.
- Reset asserted in RUN: Ready drops to 0 after that edge and the sweep reruns; prior contents are lost.
- Reset and Write asserted on the same edge: reset wins, and the write is dropped.
- No X on any output after the first reset edge.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults
  - FSM state encoding: CLEAR = 1'b0, RUN = 1'b1
  - ZERO_REG constant = 0
- One natural sub-module, reg_file_sweep: the counter plus FSM, producing clear_en, clear_addr and Ready.
- The top module holds the array, the write mux (sweep vs. user), the bypass compare and the output registers.

Test Plan:
1. Reset sweep: hold Reset = 0 for 2 edges, then release. Ready = 0 for exactly 32 edges and rises at edge 32. RDataA/RDataB = 0 throughout. Reads of all 32 addresses afterwards return 0x00000000.
2. Write then read: in RUN, Write = 1, WAddr = 5, WData = 0xDEADBEEF; next cycle RAddrA = 5, RAddrB = 5. One edge later RDataA = RDataB = 0xDEADBEEF.
3. Register 0 and write-disable:
   - Write = 1, WAddr = 0, WData = 0xFFFFFFFF, then read address 0: returns 0.
   - Write = 0, WAddr = 7, WData = 0x1234, then read address 7: returns the prior value 0.
4. Bypass: same edge Write = 1, WAddr = 9, WData = 0xA5A5A5A5, RAddrA = 9, RAddrB = 10. After that edge RDataA = 0xA5A5A5A5 and RDataB = 0.
5. Writes ignored during CLEAR: after reset release, Write = 1, WAddr = 3, WData = 0x55 at sweep cycle 10. After Ready, reading address 3 returns 0.
6. Reset mid-operation:
   - Reset = 0 at sweep cycle 15: Ready stays 0 and a full 32 further cycles elapse before Ready = 1.
   - Reset = 0 in RUN after writing 0x77 to address 12: Ready drops to 0, and after the sweep address 12 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the general register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   ZERO_REG                : index of the hardwired-zero register
//   sweep_state_e           : clear-sweep FSM encoding (CLEAR, RUN)
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/reg_file_sweep.sv
// -----------------------------------------------------------------------------
// reg_file_sweep
// Post-reset clear sequencer. After reset it steps an address through every
// array entry, one per cycle, and then reports the file ready.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   clear_en   : high while the sweep owns the array write port
//   clear_addr : array entry being zeroed this cycle
//   ready      : registered, 1 once every entry has been cleared
//   state      : current FSM state (CLEAR or RUN), exported for observation
// -----------------------------------------------------------------------------
module reg_file_sweep
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clear_en,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              ready,
    output sweep_state_e      state
);

    logic [ADDR_W-1:0] cnt;

    // The counter stops at the last entry instead of wrapping, so the sweep
    // cannot restart by itself once RUN is reached.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            if (cnt == {ADDR_W{1'b1}}) begin
                state <= RUN;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    assign clear_en   = (state == CLEAR);
    assign clear_addr = cnt;

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 2**ADDR_W x DATA_W general register file: one write port, two registered
// read ports (latency 1) with write-first bypass. Register 0 reads as zero and
// ignores writes. After reset the array is zeroed by a sweep before Ready.
//   Clk            : rising-edge clock
//   Reset          : synchronous active-low reset
//   Write          : write enable for WAddr/WData
//   WAddr, WData   : write address and data
//   RAddrA, RAddrB : read addresses
//   RDataA, RDataB : registered read data
//   Ready          : 1 once the clear sweep has finished
// -----------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Write,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic [ADDR_W-1:0] RAddrA,
    input  logic [ADDR_W-1:0] RAddrB,
    output logic [DATA_W-1:0] RDataA,
    output logic [DATA_W-1:0] RDataB,
    output logic              Ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clear_en;
    logic [ADDR_W-1:0] clear_addr;
    sweep_state_e      sweep_state;
    logic              run;
    logic              user_we;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    reg_file_sweep #(
        .ADDR_W (ADDR_W)
    ) u_sweep (
        .clk        (Clk),
        .rst_n      (Reset),
        .clear_en   (clear_en),
        .clear_addr (clear_addr),
        .ready      (Ready),
        .state      (sweep_state)
    );

    assign run     = (sweep_state == RUN);
    assign user_we = run && Write && (WAddr != ADDR_W'(ZERO_REG));

    // Array has no reset of its own; on a reset edge nothing is written so a
    // coincident user write is dropped. Sweep and user writes never overlap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if (clear_en) begin
                mem[clear_addr] <= '0;
            end else if (user_we) begin
                mem[WAddr] <= WData;
            end
        end
    end

    // Write-first: a same-edge write to the read address returns the new data.
    always_comb begin
        next_a = '0;
        if (run && (RAddrA != ADDR_W'(ZERO_REG))) begin
            next_a = (user_we && (WAddr == RAddrA)) ? WData : mem[RAddrA];
        end
    end

    always_comb begin
        next_b = '0;
        if (run && (RAddrB != ADDR_W'(ZERO_REG))) begin
            next_b = (user_we && (WAddr == RAddrB)) ? WData : mem[RAddrB];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            RDataA <= '0;
            RDataB <= '0;
        end else begin
            RDataA <= next_a;
            RDataB <= next_b;
        end
    end

endmodule
